// File: rtl/peak_hold_pkg.sv
// Shared types and constants for the peak-and-hold drive sequencer.
// Optional hold-timeout logic elsewhere is controlled by the PEAK_HOLD_TIMEOUT_EN macro.
package peak_hold_pkg;

  localparam int DEFAULT_COUNT_WIDTH = 16;
  localparam int DEFAULT_N_CHANNELS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEAK  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } phase_state_t;

  typedef logic [DEFAULT_COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/peak_hold_channel.sv
// One peak-and-hold channel: IDLE -> PEAK (latched length) -> HOLD, with an
// optional hold timeout into a sticky FAULT when PEAK_HOLD_TIMEOUT_EN is defined.
module peak_hold_channel
  import peak_hold_pkg::*;
#(
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic [COUNT_WIDTH-1:0] i_peakCount,
  input  logic [COUNT_WIDTH-1:0] i_holdMax,
  output logic                   o_muxControl,
  output logic                   o_active,
  output logic                   o_fault
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  phase_state_t           state_reg;
  logic [COUNT_WIDTH-1:0] peak_cnt_reg;
  logic [COUNT_WIDTH-1:0] peak_len_reg;
  logic                   mux_reg;
  logic                   active_reg;

`ifdef PEAK_HOLD_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] hold_cnt_reg;
  logic [COUNT_WIDTH-1:0] hold_max_reg;
  logic                   fault_reg;
`else
  logic                   unused_hold_max;
  assign unused_hold_max = ^i_holdMax;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      peak_cnt_reg <= '0;
      peak_len_reg <= '0;
      mux_reg      <= 1'b0;
      active_reg   <= 1'b0;
`ifdef PEAK_HOLD_TIMEOUT_EN
      hold_cnt_reg <= '0;
      hold_max_reg <= '0;
      fault_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_enable) begin
            // Peak length is captured once per pulse; later input changes are ignored.
            peak_len_reg <= i_peakCount;
            peak_cnt_reg <= '0;
            active_reg   <= 1'b1;
            if (i_peakCount == '0) begin
              state_reg <= HOLD;
              mux_reg   <= 1'b1;
`ifdef PEAK_HOLD_TIMEOUT_EN
              hold_cnt_reg <= '0;
              hold_max_reg <= i_holdMax;
`endif
            end else begin
              state_reg <= PEAK;
              mux_reg   <= 1'b0;
            end
          end
        end

        PEAK: begin
          if (!i_enable) begin
            state_reg    <= IDLE;
            peak_cnt_reg <= '0;
            mux_reg      <= 1'b0;
            active_reg   <= 1'b0;
          end else if (peak_cnt_reg == peak_len_reg - CNT_ONE) begin
            state_reg    <= HOLD;
            peak_cnt_reg <= '0;
            mux_reg      <= 1'b1;
`ifdef PEAK_HOLD_TIMEOUT_EN
            hold_cnt_reg <= '0;
            hold_max_reg <= i_holdMax;
`endif
          end else if (peak_cnt_reg != CNT_MAX) begin
            peak_cnt_reg <= peak_cnt_reg + CNT_ONE;
          end
        end

        HOLD: begin
          if (!i_enable) begin
            state_reg  <= IDLE;
            mux_reg    <= 1'b0;
            active_reg <= 1'b0;
`ifdef PEAK_HOLD_TIMEOUT_EN
            hold_cnt_reg <= '0;
          end else if ((hold_max_reg != '0) && (hold_cnt_reg == hold_max_reg - CNT_ONE)) begin
            // Held for exactly hold_max_reg cycles: drop the drive and latch the fault.
            state_reg    <= FAULT;
            hold_cnt_reg <= '0;
            mux_reg      <= 1'b0;
            active_reg   <= 1'b0;
            fault_reg    <= 1'b1;
          end else if (hold_cnt_reg != CNT_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + CNT_ONE;
`endif
          end
        end

`ifdef PEAK_HOLD_TIMEOUT_EN
        FAULT: begin
          if (!i_enable) begin
            state_reg <= IDLE;
            fault_reg <= 1'b0;
          end
        end
`endif

        default: begin
          state_reg    <= IDLE;
          peak_cnt_reg <= '0;
          mux_reg      <= 1'b0;
          active_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign o_muxControl = mux_reg;
  assign o_active     = active_reg;
`ifdef PEAK_HOLD_TIMEOUT_EN
  assign o_fault      = fault_reg;
`else
  assign o_fault      = 1'b0;
`endif

endmodule

// File: rtl/peak_hold_sequencer.sv
// Multi-channel peak-and-hold drive sequencer; independent channels share the
// peak/hold length inputs. Hold timeout is built in when PEAK_HOLD_TIMEOUT_EN is defined.
module peak_hold_sequencer
  import peak_hold_pkg::*;
#(
  parameter int N_CHANNELS  = DEFAULT_N_CHANNELS,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [N_CHANNELS-1:0]  i_enable,
  input  logic [COUNT_WIDTH-1:0] i_peakCount,
  input  logic [COUNT_WIDTH-1:0] i_holdMax,
  output logic [N_CHANNELS-1:0]  o_muxControl,
  output logic [N_CHANNELS-1:0]  o_active,
  output logic [N_CHANNELS-1:0]  o_fault
);

  generate
    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_channel
      peak_hold_channel #(
        .COUNT_WIDTH (COUNT_WIDTH)
      ) u_channel (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable[gi]),
        .i_peakCount  (i_peakCount),
        .i_holdMax    (i_holdMax),
        .o_muxControl (o_muxControl[gi]),
        .o_active     (o_active[gi]),
        .o_fault      (o_fault[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_peak_hold_sequencer.sv
// Directed bench for peak_hold_sequencer: a cycle table plus timing sequences.
// Timeout expectations follow PEAK_HOLD_TIMEOUT_EN.
module tb_peak_hold_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic [15:0] peak;
  logic [15:0] hmax;
  logic [3:0]  mux;
  logic [3:0]  act;
  logic [3:0]  flt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  peak_hold_sequencer #(
    .N_CHANNELS  (4),
    .COUNT_WIDTH (16)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_peakCount  (peak),
    .i_holdMax    (hmax),
    .o_muxControl (mux),
    .o_active     (act),
    .o_fault      (flt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic [15:0] peak;
    logic [15:0] hmax;
    logic [3:0]  mux;
    logic [3:0]  act;
    logic [3:0]  flt;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 4'h0;
    step();
    rst = 1'b0;
  endtask

  // Enables ch0 and returns how many edges after PEAK entry the mux flips (-1 on timeout).
  task automatic run_peak(input logic [15:0] plen, input int chg_at,
                          input logic [15:0] chg_val, output int cycles);
    peak = plen;
    en   = 4'h1;
    step();
    check4("peak_entry_active", act, 4'h1);
    check4("peak_entry_mux", mux, 4'h0);
    cycles = -1;
    for (int i = 1; i <= 200; i++) begin
      if (i == chg_at) peak = chg_val;
      step();
      if (act[3:1] !== 3'b000) check4("other_channels_idle", act, 4'h1);
      if (mux[0] === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    rst  = 1'b1;
    en   = 4'h0;
    peak = 16'd3;
    hmax = 16'd0;

    //             rst   en    peak   hmax   mux   act   flt
    vecs[0]  = '{1'b1, 4'hF, 16'd3, 16'd0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 4'hF, 16'd3, 16'd0, 4'h0, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 4'hF, 16'd3, 16'd0, 4'h0, 4'hF, 4'h0};
    vecs[3]  = '{1'b0, 4'hF, 16'd1, 16'd0, 4'h0, 4'hF, 4'h0};
    vecs[4]  = '{1'b0, 4'hE, 16'd1, 16'd0, 4'h0, 4'hE, 4'h0};
    vecs[5]  = '{1'b0, 4'hE, 16'd1, 16'd0, 4'hE, 4'hE, 4'h0};
    vecs[6]  = '{1'b0, 4'hF, 16'd1, 16'd0, 4'hE, 4'hF, 4'h0};
    vecs[7]  = '{1'b0, 4'hF, 16'd1, 16'd0, 4'hF, 4'hF, 4'h0};
    vecs[8]  = '{1'b0, 4'hF, 16'd0, 16'd0, 4'hF, 4'hF, 4'h0};
    vecs[9]  = '{1'b0, 4'h0, 16'd0, 16'd0, 4'h0, 4'h0, 4'h0};
    vecs[10] = '{1'b0, 4'h3, 16'd0, 16'd0, 4'h3, 4'h3, 4'h0};
    vecs[11] = '{1'b0, 4'h3, 16'd5, 16'd0, 4'h3, 4'h3, 4'h0};
    vecs[12] = '{1'b0, 4'h1, 16'd5, 16'd0, 4'h1, 4'h1, 4'h0};
    vecs[13] = '{1'b1, 4'h1, 16'd5, 16'd0, 4'h0, 4'h0, 4'h0};
    vecs[14] = '{1'b0, 4'h1, 16'd5, 16'd0, 4'h0, 4'h1, 4'h0};
    vecs[15] = '{1'b1, 4'h1, 16'd5, 16'd0, 4'h0, 4'h0, 4'h0};

    for (int i = 0; i < 16; i++) begin
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      peak = vecs[i].peak;
      hmax = vecs[i].hmax;
      step();
      $display("vec %0d: rst=%b en=%h peak=%0d -> mux=%h act=%h flt=%h",
               i, rst, en, peak, mux, act, flt);
      check4($sformatf("vec%0d_mux", i), mux, vecs[i].mux);
      check4($sformatf("vec%0d_act", i), act, vecs[i].act);
      check4($sformatf("vec%0d_flt", i), flt, vecs[i].flt);
    end

    // Peak timing with 20 cycles
    do_reset();
    run_peak(16'd20, 0, 16'd0, cyc);
    $display("peak20: mux rose after %0d cycles", cyc);
    check_int("peak20_len", cyc, 20);

    // Peak length latched at entry: mid-PEAK change to 5 is ignored
    do_reset();
    run_peak(16'd20, 3, 16'd5, cyc);
    $display("peak20 reload: mux rose after %0d cycles", cyc);
    check_int("peak_reload_len", cyc, 20);

    // Peak zero: mux on the same edge as active
    do_reset();
    peak = 16'd0;
    en   = 4'h1;
    step();
    $display("peak0: mux=%h act=%h", mux, act);
    check4("peak0_mux", mux, 4'h1);
    check4("peak0_act", act, 4'h1);

    // Abort in PEAK cycle 7, then full restart
    do_reset();
    peak = 16'd20;
    en   = 4'h1;
    step();
    for (int i = 0; i < 6; i++) step();
    check4("abort_pre_act", act, 4'h1);
    en = 4'h0;
    step();
    $display("abort: mux=%h act=%h flt=%h", mux, act, flt);
    check4("abort_act", act, 4'h0);
    check4("abort_mux", mux, 4'h0);
    run_peak(16'd20, 0, 16'd0, cyc);
    $display("abort restart: mux rose after %0d cycles", cyc);
    check_int("abort_restart_len", cyc, 20);

    // Hold timeout
    en = 4'h0;
    do_reset();
    peak = 16'd4;
    hmax = 16'd10;
    en   = 4'h1;
    step();
    for (int i = 0; i < 4; i++) step();
    check4("hold_entry_mux", mux, 4'h1);
    check4("hold_entry_act", act, 4'h1);
`ifdef PEAK_HOLD_TIMEOUT_EN
    cyc = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (flt[0] === 1'b1) begin
        cyc = i;
        break;
      end
    end
    $display("timeout: fault after %0d hold cycles", cyc);
    check_int("timeout_len", cyc, 10);
    check4("fault_act", act, 4'h0);
    check4("fault_mux", mux, 4'h0);
    for (int i = 0; i < 3; i++) step();
    check4("fault_sticky", flt, 4'h1);
    en = 4'h0;
    step();
    check4("fault_clear", flt, 4'h0);
    check4("fault_clear_act", act, 4'h0);
`else
    for (int i = 0; i < 30; i++) step();
    $display("no timeout: mux=%h act=%h flt=%h after 30 hold cycles", mux, act, flt);
    check4("hold_persist_mux", mux, 4'h1);
    check4("hold_persist_act", act, 4'h1);
    check4("hold_persist_flt", flt, 4'h0);
`endif

    // Staggered channels, then reset mid-HOLD
    en   = 4'h0;
    hmax = 16'd0;
    do_reset();
    peak = 16'd3;
    en = 4'h1; step();
    en = 4'h3; step();
    en = 4'h7; step();
    en = 4'hF; step();
    check4("stagger_mux0", mux, 4'h1);
    check4("stagger_act0", act, 4'hF);
    step();
    check4("stagger_mux1", mux, 4'h3);
    step();
    check4("stagger_mux2", mux, 4'h7);
    step();
    check4("stagger_mux3", mux, 4'hF);
    $display("stagger: mux=%h act=%h", mux, act);
    rst = 1'b1;
    step();
    check4("midhold_reset_act", act, 4'h0);
    check4("midhold_reset_mux", mux, 4'h0);
    check4("midhold_reset_flt", flt, 4'h0);
    rst = 1'b0;
    step();
    check4("release_act", act, 4'hF);
    check4("release_mux", mux, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
